i2c_target: RTL

- I2C target (responder) for the on-chip I2C controller.
- Lets an FPGA register bank be accessed over SCL/SDA by a bus initiator.
- Supports register-pointer write, single- and multi-byte writes, and burst reads with auto-increment (up to 11+ bytes).
- Oversamples SCL/SDA on the system clock. Exposes a strobe-based register port toward the local register file.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_line_sync.sv | 85 ++++++++
 rtl/i2c_target.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C target block: the
//               target state encoding, ACK/NACK and R/W bit values and the
//               byte width used by the shift registers and register port.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int   c_BYTE_W   = 8;

    // Bus level of the acknowledge bit
    localparam logic c_ACK      = 1'b0;
    localparam logic c_NACK     = 1'b1;

    // R/W bit appended to the 7-bit address
    localparam logic c_RW_WRITE = 1'b0;
    localparam logic c_RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        REG      = 3'd3,
        WDATA    = 3'd4,
        RDATA    = 3'd5,
        IGNORE   = 3'd6
    } target_state_t;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_sync
// Description : Brings one asynchronous I2C line (SCL or SDA) into the i_clk
//               domain and produces its level plus one-cycle rise/fall pulses.
//               With I2C_TARGET_GLITCH_FILTER_EN defined, the synchronized
//               line only changes its accepted level after FILT_LEN identical
//               consecutive samples; otherwise it feeds the edge detector
//               directly.
// Ports       : i_clk, i_rst  - clock, synchronous active-high reset
//               i_line        - raw bus line
//               o_level       - conditioned line level
//               o_rise/o_fall - one-cycle edge pulses of o_level
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2,   // must be >= 2
    parameter int FILT_LEN    = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // Lines idle high; resetting the chain to 1 avoids a false edge after reset.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_level;
    logic                   r_prev;

    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("FILT_LEN must be at least 1");
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int c_CNT_W = $clog2(FILT_LEN + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_filt;

    // r_cnt counts consecutive samples that disagree with the accepted level;
    // the FILT_LEN-th such sample flips the accepted level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == c_CNT_W'(FILT_LEN - 1)) begin
            r_filt <= r_sync[SYNC_STAGES-1];
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule : i2c_line_sync
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target
// Description : I2C target giving a bus initiator access to a local register
//               file. Supports pointer write, single/multi-byte writes with
//               pointer auto-increment and burst reads. SCL/SDA are
//               oversampled on i_clk; SCL is never stretched.
//               Optional glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
// Ports       : i_clk, i_rst    - clock, synchronous active-high reset
//               i_dev_addr      - 7-bit device address
//               i2c_scl/i2c_sda - bus clock in / open-drain data
//               i_rd_data       - register data, valid 1 cycle after o_rd_stb
//               o_reg_addr      - register pointer
//               o_wr_data       - last received write byte
//               o_wr_stb        - write strobe (1 cycle)
//               o_rd_stb        - read strobe (1 cycle)
//               o_busy          - target currently addressed
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [6:0]          i_dev_addr,
    input  logic                i2c_scl,
    inout  wire                 i2c_sda,
    input  logic [c_BYTE_W-1:0] i_rd_data,
    output logic [c_BYTE_W-1:0] o_reg_addr,
    output logic [c_BYTE_W-1:0] o_wr_data,
    output logic                o_wr_stb,
    output logic                o_rd_stb,
    output logic                o_busy
);

    localparam logic [3:0] c_CNT_BYTE = 4'(c_BYTE_W);      // all data bits seen
    localparam logic [3:0] c_CNT_ACK  = 4'(c_BYTE_W + 1);  // inside 9th clock
    localparam logic [3:0] c_CNT_MACK = 4'(c_BYTE_W + 2);  // master ACKed a read byte

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    target_state_t       r_state,    w_state;
    logic [3:0]          r_bit_cnt,  w_bit_cnt;
    logic [c_BYTE_W-1:0] r_shift,    w_shift;
    logic [c_BYTE_W-1:0] r_tx,       w_tx;
    logic [c_BYTE_W-1:0] r_ptr,      w_ptr;
    logic [c_BYTE_W-1:0] r_wr_data,  w_wr_data;
    logic                r_wr_stb,   w_wr_stb;
    logic                r_rd_stb,   w_rd_stb;
    logic                r_sda_oe,   w_sda_oe;
    logic                r_busy,     w_busy;
    logic                r_rw,       w_rw;
    logic                r_cap;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_line (i2c_scl),
        .o_level(w_scl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_line (i2c_sda),
        .o_level(w_sda),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_ptr     <= '0;
            r_wr_data <= '0;
            r_wr_stb  <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= c_RW_WRITE;
            r_cap     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_bit_cnt <= w_bit_cnt;
            r_shift   <= w_shift;
            r_tx      <= w_tx;
            r_ptr     <= w_ptr;
            r_wr_data <= w_wr_data;
            r_wr_stb  <= w_wr_stb;
            r_rd_stb  <= w_rd_stb;
            r_sda_oe  <= w_sda_oe;
            r_busy    <= w_busy;
            r_rw      <= w_rw;
            // i_rd_data is valid the cycle after the strobe, so capture one
            // cycle after r_rd_stb is seen.
            r_cap     <= r_rd_stb;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_tx      = r_tx;
        w_ptr     = r_ptr;
        w_wr_data = r_wr_data;
        w_wr_stb  = 1'b0;
        w_rd_stb  = 1'b0;
        w_sda_oe  = r_sda_oe;
        w_busy    = r_busy;
        w_rw      = r_rw;

        if (w_start) begin
            w_state   = ADDR;
            w_bit_cnt = '0;
            w_sda_oe  = 1'b0;
            w_busy    = 1'b0;
        end else if (w_stop) begin
            w_state   = IDLE;
            w_sda_oe  = 1'b0;
            w_busy    = 1'b0;
        end else begin
            // Fetched read data arrives mid SCL-low. After the master's ACK
            // the first bit is driven as soon as it lands, a couple of cycles
            // later than the other bits but still well before SCL rises.
            if (r_cap) begin
                if (r_state == RDATA) begin
                    w_sda_oe  = ~i_rd_data[c_BYTE_W-1];
                    w_tx      = {i_rd_data[c_BYTE_W-2:0], 1'b0};
                    w_bit_cnt = 4'd1;
                end else begin
                    w_tx      = i_rd_data;
                end
            end

            case (r_state)
                ADDR, REG, WDATA: begin
                    if (w_scl_rise && (r_bit_cnt < c_CNT_BYTE)) begin
                        w_shift   = {r_shift[c_BYTE_W-2:0], w_sda};
                        w_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == c_CNT_BYTE)) begin
                        w_bit_cnt = c_CNT_ACK;
                        if (r_state == ADDR) begin
                            if (r_shift[c_BYTE_W-1:1] == i_dev_addr) begin
                                w_state  = ADDR_ACK;
                                w_sda_oe = 1'b1;
                                w_busy   = 1'b1;
                                w_rw     = r_shift[0];
                                w_rd_stb = (r_shift[0] == c_RW_READ);
                            end else begin
                                w_state  = IGNORE;
                            end
                        end else if (r_state == REG) begin
                            w_ptr    = r_shift;
                            w_sda_oe = 1'b1;
                        end else begin
                            w_wr_stb  = 1'b1;
                            w_wr_data = r_shift;
                            w_sda_oe  = 1'b1;
                        end
                    end else if (w_scl_fall && (r_bit_cnt == c_CNT_ACK)) begin
                        // End of our ACK clock
                        w_sda_oe  = 1'b0;
                        w_bit_cnt = '0;
                        if (r_state == REG) begin
                            w_state = WDATA;
                        end else if (r_state == WDATA) begin
                            w_ptr = r_ptr + 8'd1;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw == c_RW_WRITE) begin
                            w_state   = REG;
                            w_sda_oe  = 1'b0;
                            w_bit_cnt = '0;
                        end else begin
                            w_state   = RDATA;
                            w_sda_oe  = ~r_tx[c_BYTE_W-1];
                            w_tx      = {r_tx[c_BYTE_W-2:0], 1'b0};
                            w_bit_cnt = 4'd1;
                        end
                    end
                end

                RDATA: begin
                    // r_bit_cnt: 1..7 bits driven, 8 all driven, 9 master
                    // ACK clock, 10 master ACKed and next fetch pending.
                    if (w_scl_fall) begin
                        if ((r_bit_cnt != 4'd0) && (r_bit_cnt < c_CNT_BYTE)) begin
                            w_sda_oe  = ~r_tx[c_BYTE_W-1];
                            w_tx      = {r_tx[c_BYTE_W-2:0], 1'b0};
                            w_bit_cnt = r_bit_cnt + 4'd1;
                        end else if (r_bit_cnt == c_CNT_BYTE) begin
                            w_sda_oe  = 1'b0;
                            w_bit_cnt = c_CNT_ACK;
                        end else if (r_bit_cnt == c_CNT_MACK) begin
                            w_rd_stb  = 1'b1;
                            w_bit_cnt = '0;
                        end
                    end else if (w_scl_rise && (r_bit_cnt == c_CNT_ACK)) begin
                        if (w_sda == c_ACK) begin
                            w_ptr     = r_ptr + 8'd1;
                            w_bit_cnt = c_CNT_MACK;
                        end else begin
                            w_state   = IGNORE;
                            w_busy    = 1'b0;
                        end
                    end
                end

                IDLE, IGNORE: begin
                    w_sda_oe = 1'b0;
                end

                default: begin
                    w_state  = IDLE;
                    w_sda_oe = 1'b0;
                end
            endcase
        end
    end

    assign i2c_sda    = r_sda_oe ? 1'b0 : 1'bz;
    assign o_reg_addr = r_ptr;
    assign o_wr_data  = r_wr_data;
    assign o_wr_stb   = r_wr_stb;
    assign o_rd_stb   = r_rd_stb;
    assign o_busy     = r_busy;

endmodule : i2c_target
`default_nettype wire
